// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM with registered control word, combinational pcen/alucontrol.
// Define MULTICYCLE_CTRL_LUI_EN to add the LUIEX state for op 001111 (lui).
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       luisrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        LUIEX   = 4'd12
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic       luisrc;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl;

    // Control word of a state; the register loads the word of the state being entered.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RTYPEWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            LUIEX: begin
                c.alusrca = 1'b1;
`ifdef MULTICYCLE_CTRL_LUI_EN
                c.luisrc  = 1'b1;
`endif
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (op)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000:            nxt = RTYPEEX;
                    6'b000100:            nxt = BEQEX;
                    6'b001000:            nxt = ADDIEX;
                    6'b000010:            nxt = JEX;
`ifdef MULTICYCLE_CTRL_LUI_EN
                    6'b001111:            nxt = LUIEX;
`else
                    6'b001111:            nxt = FETCH;
`endif
                    default:              nxt = FETCH;
                endcase
            end
            MEMADR:  nxt = (op == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            LUIEX:   nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur  <= FETCH;
            ctrl <= decode(FETCH);
        end else begin
            cur  <= nxt;
            ctrl <= decode(nxt);
        end
    end

    always_comb begin
        alucontrol = 3'b000;
        case (ctrl.aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    // Branch resolves in the same cycle the ALU reports zero.
    assign pcen     = ctrl.pcwrite | (ctrl.branch & zero);
    assign irwrite  = ctrl.irwrite;
    assign memwrite = ctrl.memwrite;
    assign regwrite = ctrl.regwrite;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign luisrc   = ctrl.luisrc;
    assign state    = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: instruction-level model of state sequences and per-state controls.
// Honors MULTICYCLE_CTRL_LUI_EN the same way as the design.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, luisrc;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks = 0;
    int passes = 0;
    int expSeq[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .luisrc(luisrc),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] observed();
        return {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, luisrc};
    endfunction

    function automatic logic [2:0] rtypeAlu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Expected control outputs for a state number, given the current funct and zero inputs.
    function automatic logic [15:0] expCtrl(input int s, input logic [5:0] f, input logic z);
        logic       e_pcen = 0, e_ir = 0, e_mw = 0, e_rw = 0, e_iord = 0, e_m2r = 0, e_rd = 0, e_sa = 0, e_lui = 0;
        logic [1:0] e_sb = 2'b00, e_pcs = 2'b00;
        logic [2:0] e_alu = 3'b010;
        case (s)
            0:  begin e_pcen = 1; e_ir = 1; e_sb = 2'b01; end
            1:  e_sb = 2'b11;
            2:  begin e_sa = 1; e_sb = 2'b10; end
            3:  e_iord = 1;
            4:  begin e_rw = 1; e_m2r = 1; end
            5:  begin e_iord = 1; e_mw = 1; end
            6:  begin e_sa = 1; e_alu = rtypeAlu(f); end
            7:  begin e_rw = 1; e_rd = 1; end
            8:  begin e_sa = 1; e_alu = 3'b110; e_pcs = 2'b01; e_pcen = z; end
            9:  begin e_sa = 1; e_sb = 2'b10; end
            10: e_rw = 1;
            11: begin e_pcs = 2'b10; e_pcen = 1; end
            12: begin e_sa = 1; e_lui = 1; end
            default: ;
        endcase
        return {e_pcen, e_ir, e_mw, e_rw, e_iord, e_m2r, e_rd, e_sa, e_sb, e_pcs, e_alu, e_lui};
    endfunction

    function automatic void buildSeq(input logic [5:0] o);
        expSeq = {0, 1};
        case (o)
            6'b100011: expSeq = {0, 1, 2, 3, 4};
            6'b101011: expSeq = {0, 1, 2, 5};
            6'b000000: expSeq = {0, 1, 6, 7};
            6'b000100: expSeq = {0, 1, 8};
            6'b001000: expSeq = {0, 1, 9, 10};
            6'b000010: expSeq = {0, 1, 11};
`ifdef MULTICYCLE_CTRL_LUI_EN
            6'b001111: expSeq = {0, 1, 12, 10};
`endif
            default: ;
        endcase
    endfunction

    // zmode: 0/1 force zero, 2 randomize it every cycle.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input int zmode);
        op = o;
        funct = f;
        buildSeq(o);
        foreach (expSeq[i]) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            #1;
            checkOutput($sformatf("state[%0d] op=%b", i, o), {12'b0, state}, 16'(expSeq[i]));
            checkOutput($sformatf("ctrl s%0d op=%b f=%b z=%b", expSeq[i], o, f, zero),
                        observed(), expCtrl(expSeq[i], f, zero));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetInMemwr();
        int walk[$];
        walk = {0, 1, 2};
        op = 6'b101011;
        funct = 6'($urandom);
        foreach (walk[i]) begin
            #1;
            checkOutput("sw walk state", {12'b0, state}, 16'(walk[i]));
            @(posedge clk);
            #1;
        end
        #1;
        checkOutput("sw in MEMWR", {12'b0, state}, 16'd5);
        checkOutput("MEMWR ctrl", observed(), expCtrl(5, funct, zero));
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset state", {12'b0, state}, 16'd0);
        checkOutput("async reset memwrite", {15'b0, memwrite}, 16'd0);
        checkOutput("async reset ctrl", observed(), expCtrl(0, funct, zero));
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [5:0] opList[7];
        logic [5:0] fnList[5];
        logic [5:0] o, f;
        opList = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b001111};
        fnList = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset = 1'b1;
        op = 6'b100011;
        funct = 6'b0;
        zero = 1'b0;
        #2;
        checkOutput("reset state", {12'b0, state}, 16'd0);
        checkOutput("reset ctrl", observed(), expCtrl(0, funct, zero));
        @(posedge clk);
        #1;
        checkOutput("reset held across edge", {12'b0, state}, 16'd0);
        #2 reset = 1'b0;

        applyStimulus(6'b100011, 6'b000000, 2);
        applyStimulus(6'b000000, 6'b101010, 2);
        applyStimulus(6'b000100, 6'b000000, 1);
        applyStimulus(6'b000100, 6'b000000, 0);
        applyStimulus(6'b000010, 6'b000000, 2);
        applyStimulus(6'b111111, 6'b000000, 2);
        applyStimulus(6'b001111, 6'b000000, 2);
        resetInMemwr();
        applyStimulus(6'b101011, 6'b100101, 2);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 8);
            o = (k >= 7) ? 6'($urandom) : opList[k];
            k = $urandom_range(0, 5);
            f = (k == 5) ? 6'($urandom) : fnList[k];
            applyStimulus(o, f, 2);
        end

        #1;
        checkOutput("final state", {12'b0, state}, 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
